// File: rtl/aes_mixcol_axil_engine.sv
// AXI4-Lite slave applying AES MixColumns / InvMixColumns to NUM_COLS 32-bit columns, one column per cycle.
// Latency NUM_COLS+1 cycles from START acceptance; one outstanding write and one outstanding read, held until bready/rready.
module aes_mixcol_axil_engine #(
    parameter int NUM_COLS           = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready
);
    localparam int AW = C_S_AXI_ADDR_WIDTH - 2;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q;
    logic [1:0]  col_q;
    logic        mode_q, done_q;
    logic        awready_q, arready_q, bvalid_q, rvalid_q;
    logic [1:0]  bresp_q;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] din_q  [NUM_COLS];
    logic [31:0] dout_q [NUM_COLS];

    logic [AW-1:0] wword, rword;
    logic wr_fire, rd_fire, busy, wr_din, wr_ctrl, wr_stat, wr_err, start, last;
    logic unused_ok;

    assign wword   = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign rword   = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_fire = awready_q & s00_axi_awvalid & s00_axi_wvalid;
    assign rd_fire = arready_q & s00_axi_arvalid;
    assign busy    = (state_q == RUN);
    assign wr_din  = (wword < AW'(4));
    assign wr_ctrl = (wword == AW'(8));
    assign wr_stat = (wword == AW'(9));
    assign wr_err  = busy & (wr_din | wr_ctrl);
    assign start   = wr_fire & wr_ctrl & ~busy & s00_axi_wstrb[0] & s00_axi_wdata[0];
    assign last    = (col_q == 2'(NUM_COLS - 1));

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = awready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Row r lives in byte r; x2/x4/x8 are the doubling chain used by both directions.
    function automatic logic [31:0] mix_col(input logic [31:0] a, input logic inv);
        logic [7:0]  x1 [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [31:0] o;
        logic [1:0]  i0, i1, i2, i3;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            x1[r] = a[8*r +: 8];
            x2[r] = xt(x1[r]);
            x4[r] = xt(x2[r]);
            x8[r] = xt(x4[r]);
        end
        for (int r = 0; r < 4; r++) begin
            i0 = 2'(r);
            i1 = 2'(r + 1);
            i2 = 2'(r + 2);
            i3 = 2'(r + 3);
            if (inv)
                o[8*r +: 8] = (x8[i0] ^ x4[i0] ^ x2[i0]) ^ (x8[i1] ^ x2[i1] ^ x1[i1])
                            ^ (x8[i2] ^ x4[i2] ^ x1[i2]) ^ (x8[i3] ^ x1[i3]);
            else
                o[8*r +: 8] = x2[i0] ^ x2[i1] ^ x1[i1] ^ x1[i2] ^ x1[i3];
        end
        return o;
    endfunction

    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (rword == AW'(i))     rdata_d = din_q[i];
            if (rword == AW'(4 + i)) rdata_d = dout_q[i];
        end
        if (rword == AW'(8)) rdata_d = {30'b0, mode_q, 1'b0};
        if (rword == AW'(9)) rdata_d = {30'b0, done_q, busy};
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= IDLE;
            col_q     <= '0;
            mode_q    <= 1'b0;
            done_q    <= 1'b0;
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rdata_q   <= '0;
            for (int i = 0; i < NUM_COLS; i++) begin
                din_q[i]  <= '0;
                dout_q[i] <= '0;
            end
        end else begin
            awready_q <= s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q & ~awready_q;
            arready_q <= s00_axi_arvalid & ~rvalid_q & ~arready_q;

            if (wr_fire) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_err ? 2'b10 : 2'b00;
            end else if (s00_axi_bready) begin
                bvalid_q <= 1'b0;
            end

            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
            end else if (s00_axi_rready) begin
                rvalid_q <= 1'b0;
            end

            if (wr_fire && !busy) begin
                for (int i = 0; i < NUM_COLS; i++)
                    if (wword == AW'(i))
                        for (int b = 0; b < 4; b++)
                            if (s00_axi_wstrb[b]) din_q[i][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
                if (wr_ctrl && s00_axi_wstrb[0]) mode_q <= s00_axi_wdata[1];
            end

            if (wr_fire && wr_stat && s00_axi_wstrb[0] && s00_axi_wdata[1]) done_q <= 1'b0;

            // Completion is evaluated after the clear so a coincident clear loses.
            case (state_q)
                IDLE: if (start) begin
                    state_q <= RUN;
                    col_q   <= '0;
                    done_q  <= 1'b0;
                end
                RUN: begin
                    for (int i = 0; i < NUM_COLS; i++)
                        if (col_q == 2'(i)) dout_q[i] <= mix_col(din_q[i], mode_q);
                    col_q <= col_q + 2'd1;
                    if (last) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_mixcol_axil_engine.sv
// Directed bench for aes_mixcol_axil_engine: a 4-column and a 2-column instance driven over AXI4-Lite.
module tb_aes_mixcol_axil_engine;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [5:0]  awaddr [2], araddr [2];
    logic [2:0]  awprot [2], arprot [2];
    logic        awvalid [2], awready [2], wvalid [2], wready [2];
    logic        bvalid [2], bready [2], arvalid [2], arready [2], rvalid [2], rready [2];
    logic [31:0] wdata [2], rdata [2];
    logic [3:0]  wstrb [2];
    logic [1:0]  bresp [2], rresp [2];

    int n_checks = 0;
    int n_errors = 0;

    aes_mixcol_axil_engine #(.NUM_COLS(4)) u_dut4 (
        .ACLK(clk), .ARESET(rst),
        .s00_axi_awaddr(awaddr[0]), .s00_axi_awprot(awprot[0]), .s00_axi_awvalid(awvalid[0]), .s00_axi_awready(awready[0]),
        .s00_axi_wdata(wdata[0]), .s00_axi_wstrb(wstrb[0]), .s00_axi_wvalid(wvalid[0]), .s00_axi_wready(wready[0]),
        .s00_axi_bresp(bresp[0]), .s00_axi_bvalid(bvalid[0]), .s00_axi_bready(bready[0]),
        .s00_axi_araddr(araddr[0]), .s00_axi_arprot(arprot[0]), .s00_axi_arvalid(arvalid[0]), .s00_axi_arready(arready[0]),
        .s00_axi_rdata(rdata[0]), .s00_axi_rresp(rresp[0]), .s00_axi_rvalid(rvalid[0]), .s00_axi_rready(rready[0])
    );

    aes_mixcol_axil_engine #(.NUM_COLS(2)) u_dut2 (
        .ACLK(clk), .ARESET(rst),
        .s00_axi_awaddr(awaddr[1]), .s00_axi_awprot(awprot[1]), .s00_axi_awvalid(awvalid[1]), .s00_axi_awready(awready[1]),
        .s00_axi_wdata(wdata[1]), .s00_axi_wstrb(wstrb[1]), .s00_axi_wvalid(wvalid[1]), .s00_axi_wready(wready[1]),
        .s00_axi_bresp(bresp[1]), .s00_axi_bvalid(bvalid[1]), .s00_axi_bready(bready[1]),
        .s00_axi_araddr(araddr[1]), .s00_axi_arprot(arprot[1]), .s00_axi_arvalid(arvalid[1]), .s00_axi_arready(arready[1]),
        .s00_axi_rdata(rdata[1]), .s00_axi_rresp(rresp[1]), .s00_axi_rvalid(rvalid[1]), .s00_axi_rready(rready[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic aw_accept(input int s, input logic [5:0] a, input logic [31:0] d, input logic [3:0] st);
        int n;
        awaddr[s] = a; wdata[s] = d; wstrb[s] = st;
        awvalid[s] = 1'b1; wvalid[s] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!awready[s] && n < 50) begin @(negedge clk); n++; end
        if (!awready[s]) check("aw_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        awvalid[s] = 1'b0; wvalid[s] = 1'b0;
        @(negedge clk);
    endtask

    task automatic b_get(input int s, output logic [1:0] resp);
        int n;
        n = 0;
        while (!bvalid[s] && n < 50) begin @(negedge clk); n++; end
        if (!bvalid[s]) check("b_timeout", 32'd0, 32'd1);
        resp = bresp[s];
        @(negedge clk);
    endtask

    task automatic axi_write(input int s, input logic [5:0] a, input logic [31:0] d, input logic [3:0] st,
                             output logic [1:0] resp);
        aw_accept(s, a, d, st);
        b_get(s, resp);
    endtask

    task automatic ar_accept(input int s, input logic [5:0] a);
        int n;
        araddr[s] = a; arvalid[s] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready[s] && n < 50) begin @(negedge clk); n++; end
        if (!arready[s]) check("ar_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        arvalid[s] = 1'b0;
        @(negedge clk);
    endtask

    task automatic r_get(input int s, output logic [31:0] d);
        int n;
        n = 0;
        while (!rvalid[s] && n < 50) begin @(negedge clk); n++; end
        if (!rvalid[s]) check("r_timeout", 32'd0, 32'd1);
        d = rdata[s];
        if (rresp[s] !== 2'b00) check("rresp", 32'(rresp[s]), 32'd0);
        @(negedge clk);
    endtask

    task automatic axi_read(input int s, input logic [5:0] a, output logic [31:0] d);
        ar_accept(s, a);
        r_get(s, d);
    endtask

    task automatic read_check(input int s, input logic [5:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        axi_read(s, a, d);
        check(tag, d, exp);
    endtask

    // Called at the negedge of cycle 1, i.e. the cycle after START was accepted.
    task automatic watch_run(input int s, output int busy_n, output int done_at);
        logic b, dn;
        busy_n = 0; done_at = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            b  = (s == 0) ? u_dut4.busy   : u_dut2.busy;
            dn = (s == 0) ? u_dut4.done_q : u_dut2.done_q;
            if (b) busy_n++;
            if (dn && done_at == 0) done_at = cyc;
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int s);
        logic [31:0] st;
        int n;
        n = 0;
        axi_read(s, 6'h24, st);
        while (!st[1] && n < 30) begin axi_read(s, 6'h24, st); n++; end
        check("wait_done", 32'(st[1]), 32'd1);
    endtask

    logic [31:0] mix_in  [4] = '{32'h455313DB, 32'h5C220AF2, 32'hC6C6C6C6, 32'h01010101};
    logic [31:0] mix_out [4] = '{32'hBCA14D8E, 32'h9D58DC9F, 32'hC6C6C6C6, 32'h01010101};

    initial begin
        logic [1:0]  resp;
        logic [31:0] d;
        int busy_n, done_at;
        logic seen, held;

        for (int s = 0; s < 2; s++) begin
            awaddr[s] = '0; araddr[s] = '0; awprot[s] = '0; arprot[s] = '0;
            awvalid[s] = 1'b0; wvalid[s] = 1'b0; arvalid[s] = 1'b0;
            wdata[s] = '0; wstrb[s] = '0; bready[s] = 1'b1; rready[s] = 1'b1;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_handshake", {27'b0, awready[0], wready[0], arready[0], bvalid[0], rvalid[0]}, 32'd0);
        check("rst_resp_data", {rdata[0][29:0], bresp[0]}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        read_check(0, 6'h24, 32'h0, "rst_status");
        read_check(0, 6'h20, 32'h0, "rst_ctrl");
        read_check(0, 6'h10, 32'h0, "rst_dout0");

        // Forward MixColumns over four columns with cycle-exact BUSY/DONE.
        for (int c = 0; c < 4; c++) axi_write(0, 6'(4*c), mix_in[c], 4'hF, resp);
        aw_accept(0, 6'h20, 32'h1, 4'h1);
        check("start_bresp", {30'b0, bresp[0]}, 32'd0);
        watch_run(0, busy_n, done_at);
        check("mix_busy_cycles", 32'(busy_n), 32'd4);
        check("mix_done_cycle", 32'(done_at), 32'd5);
        for (int c = 0; c < 4; c++) read_check(0, 6'(16 + 4*c), mix_out[c], $sformatf("mix_dout%0d", c));
        read_check(0, 6'h24, 32'h2, "status_done");
        axi_write(0, 6'h24, 32'h2, 4'h1, resp);
        read_check(0, 6'h24, 32'h0, "status_cleared");

        // Inverse round trip restores the original columns.
        for (int c = 0; c < 4; c++) axi_write(0, 6'(4*c), mix_out[c], 4'hF, resp);
        axi_write(0, 6'h20, 32'h3, 4'h1, resp);
        wait_done(0);
        for (int c = 0; c < 4; c++) read_check(0, 6'(16 + 4*c), mix_in[c], $sformatf("inv_dout%0d", c));
        read_check(0, 6'h20, 32'h2, "ctrl_mode_readback");

        // Busy protection: DATA_IN write and START write are refused, STATUS write is not.
        aw_accept(0, 6'h20, 32'h1, 4'h1);
        fork
            watch_run(0, busy_n, done_at);
            axi_write(0, 6'h04, 32'hFFFFFFFF, 4'hF, resp);
        join
        check("busy_din_bresp", {30'b0, resp}, 32'd2);
        check("busy_din_done_cycle", 32'(done_at), 32'd5);
        read_check(0, 6'h04, 32'h9D58DC9F, "busy_din_unchanged");
        aw_accept(0, 6'h20, 32'h1, 4'h1);
        fork
            watch_run(0, busy_n, done_at);
            axi_write(0, 6'h20, 32'h1, 4'h1, resp);
        join
        check("busy_start_bresp", {30'b0, resp}, 32'd2);
        check("busy_start_one_run", 32'(busy_n), 32'd4);
        check("busy_start_done_cycle", 32'(done_at), 32'd5);
        aw_accept(0, 6'h20, 32'h1, 4'h1);
        fork
            watch_run(0, busy_n, done_at);
            axi_write(0, 6'h24, 32'h2, 4'h1, resp);
        join
        check("busy_status_bresp", {30'b0, resp}, 32'd0);
        check("busy_status_done_cycle", 32'(done_at), 32'd5);

        // Two-column build.
        axi_write(1, 6'h08, 32'h12345678, 4'hF, resp);
        read_check(1, 6'h08, 32'h0, "n2_din2_unmapped");
        read_check(1, 6'h18, 32'h0, "n2_dout2");
        read_check(1, 6'h1C, 32'h0, "n2_dout3");
        axi_write(1, 6'h00, mix_in[0], 4'hF, resp);
        axi_write(1, 6'h04, mix_in[1], 4'hF, resp);
        aw_accept(1, 6'h20, 32'h1, 4'h1);
        watch_run(1, busy_n, done_at);
        check("n2_busy_cycles", 32'(busy_n), 32'd2);
        check("n2_done_cycle", 32'(done_at), 32'd3);
        read_check(1, 6'h10, mix_out[0], "n2_dout0");
        read_check(1, 6'h14, mix_out[1], "n2_dout1");

        // Byte strobes.
        axi_write(0, 6'h00, 32'h0, 4'hF, resp);
        axi_write(0, 6'h00, 32'hAABBCCDD, 4'b0101, resp);
        read_check(0, 6'h00, 32'h00BB00DD, "wstrb_merge");

        // Write-response backpressure blocks the next write.
        bready[0] = 1'b0;
        aw_accept(0, 6'h04, 32'h11, 4'hF);
        awaddr[0] = 6'h08; wdata[0] = 32'h22; wstrb[0] = 4'hF; awvalid[0] = 1'b1; wvalid[0] = 1'b1;
        seen = 1'b0; held = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (awready[0]) seen = 1'b1;
            if (!bvalid[0]) held = 1'b0;
        end
        check("bp_bvalid_held", 32'(held), 32'd1);
        check("bp_no_aw_accept", 32'(seen), 32'd0);
        awvalid[0] = 1'b0; wvalid[0] = 1'b0; bready[0] = 1'b1;
        b_get(0, resp);
        read_check(0, 6'h08, 32'hC6C6C6C6, "bp_second_write_blocked");

        // Read-data backpressure blocks the next read.
        rready[0] = 1'b0;
        ar_accept(0, 6'h04);
        araddr[0] = 6'h00; arvalid[0] = 1'b1;
        seen = 1'b0; held = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (arready[0]) seen = 1'b1;
            if (!rvalid[0]) held = 1'b0;
        end
        check("bp_rvalid_held", 32'(held), 32'd1);
        check("bp_no_ar_accept", 32'(seen), 32'd0);
        arvalid[0] = 1'b0; rready[0] = 1'b1;
        r_get(0, d);
        check("bp_read_data", d, 32'h00000011);

        // Reset in cycle 2 of a run.
        aw_accept(0, 6'h20, 32'h1, 4'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstrun_no_resp", {30'b0, bvalid[0], rvalid[0]}, 32'd0);
        read_check(0, 6'h24, 32'h0, "rstrun_status");
        for (int c = 0; c < 4; c++) read_check(0, 6'(16 + 4*c), 32'h0, $sformatf("rstrun_dout%0d", c));
        axi_write(0, 6'h00, mix_in[0], 4'hF, resp);
        axi_write(0, 6'h20, 32'h1, 4'h1, resp);
        wait_done(0);
        read_check(0, 6'h10, mix_out[0], "rstrun_after_dout0");
        read_check(0, 6'h14, 32'h0, "rstrun_after_dout1");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/aes_mixcol_axil_engine.md
# aes_mixcol_axil_engine

AXI4-Lite slave that applies AES MixColumns or InvMixColumns to a parametrised number of 32-bit state columns. It is the parametrised successor of the single-function mix/inverse-mix peripheral: mode is selected at run time, work is started explicitly, and BUSY/DONE status is exposed. It sits on the PS AXI4-Lite interconnect beside the other AES round-function IPs, and software drives it by register access.

## Interface
- NUM_COLS, 4, number of state columns processed per START; legal 1..4
- C_S_AXI_DATA_WIDTH, 32, fixed; other values are illegal
- C_S_AXI_ADDR_WIDTH, 6, byte address width
- ACLK  in  1  sole clock; all logic on the rising edge
- ARESET  in  1  synchronous, active-high reset
- s00_axi_awaddr / awprot / awvalid / awready  in/in/in/out  ADDR_W/3/1/1  write address channel; awprot ignored
- s00_axi_wdata / wstrb / wvalid / wready  in/in/in/out  32/4/1/1  write data channel
- s00_axi_bresp / bvalid / bready  out/out/in  2/1/1  write response channel
- s00_axi_araddr / arprot / arvalid / arready  in/in/in/out  ADDR_W/3/1/1  read address channel; arprot ignored
- s00_axi_rdata / rresp / rvalid / rready  out/out/out/in  32/2/1/1  read data channel

## Operation
- Register map (byte offsets; addr[1:0] ignored):
  - 0x00–0x0C DATA_IN[c], RW. Row r of the column is held in bits [8r+7:8r]. Each byte is written only when its wstrb bit is set.
  - 0x10–0x1C DATA_OUT[c], RO. Writes to it are ignored and return OKAY.
  - 0x20 CTRL. Bit0 START reads as 0; writing 1 starts a run. Bit1 MODE is RW: 0 = MixColumns, 1 = InvMixColumns. Only wstrb[0] is honoured.
  - 0x24 STATUS. Bit0 BUSY is RO. Bit1 DONE is sticky; writing 1 to it clears it.
  - Column index c ≥ NUM_COLS and any unmapped address: reads return 0, writes are ignored, response is OKAY.
- FSM states: IDLE and RUN.
  - IDLE → RUN when a CTRL write with wdata[0]=1 and wstrb[0]=1 completes. DONE clears and the column counter is set to 0.
  - In RUN, each cycle: DATA_OUT[k] ← f(DATA_IN[k]), then k increments. When k = NUM_COLS−1, return to IDLE and set DONE.
  - BUSY is high whenever the state is RUN.
- While BUSY, writes to DATA_IN, MODE or START are dropped and return bresp SLVERR (2'b10). STATUS writes are still accepted. Reads are always OKAY.
- If a CTRL write carries START=1 and a new MODE in the same access, the new MODE is used for that run.
- Arithmetic (GF(2^8), polynomial 0x11B):
  - xtime(b) = {b[6:0],0} ^ (b[7] ? 8'h1B : 0).
  - Mix: o_r = 2·a_r ^ 3·a_{r+1} ^ a_{r+2} ^ a_{r+3}, with row indices taken mod 4.
  - Inverse: o_r = 0E·a_r ^ 0B·a_{r+1} ^ 0D·a_{r+2} ^ 09·a_{r+3}.
  - The datapath is purely combinational within a single cycle, followed by a register.

## Timing
- Reset values: awready, wready, arready, bvalid and rvalid are 0; bresp, rresp and rdata are 0. All registers are 0, the state is IDLE, and BUSY = DONE = 0.
- Write handshake:
  - awready and wready pulse high together for one cycle, only when awvalid & wvalid & !bvalid.
  - The register update happens on that edge.
  - bvalid rises the next cycle and holds until bready. No new write is accepted while bvalid is high.
- Read handshake:
  - arready pulses for one cycle when arvalid & !rvalid.
  - rdata/rresp are registered on that edge, and rvalid rises the next cycle and holds until rready.
  - Read data is sampled at acceptance.
- Run timing, with the START write accepted in cycle 0:
  - BUSY is 1 in cycles 1..NUM_COLS.
  - DATA_OUT[k] is valid from cycle k+2.
  - DONE = 1 and BUSY = 0 from cycle NUM_COLS+1.
  - Total latency is NUM_COLS+1 cycles.
- Simultaneous events:
  - A DONE-clear write in the same cycle that the run completes leaves DONE = 1, because set wins.
  - Read and write channels operate independently. A same-cycle read of a register being written returns the old value.
- ARESET asserted mid-run or mid-handshake: everything is reset on the next edge, with no partial response and DONE = 0.

## Test plan
- Mix, NUM_COLS=4: write DATA_IN = {0x455313DB, 0x5C220AF2, 0xC6C6C6C6, 0x01010101}, MODE=0, START. Required: DATA_OUT = {0xBCA14D8E, 0x9D58DC9F, 0xC6C6C6C6, 0x01010101}; DONE set exactly 5 cycles after START acceptance; BUSY high for exactly 4 cycles.
- Inverse: DATA_IN[0] = 0xBCA14D8E, MODE=1, START. Required: DATA_OUT[0] = 0x455313DB. A round trip over all 4 columns restores the originals.
- Busy protection: during RUN, write DATA_IN[1] = 0xFFFFFFFF and write START. Required: both return bresp=2'b10, DATA_IN[1] is unchanged, and the run ends at its original cycle. A STATUS write of 0x2 during RUN returns OKAY.
- NUM_COLS=2 build: DATA_IN[2] write reads back 0 and DATA_OUT[2]/[3] read 0. DONE follows START acceptance by 3 cycles.
- Strobes and backpressure: write 0xAABBCCDD with wstrb=4'b0101 over DATA_IN[0]=0. Required: reads back 0x00BB00DD. Holding bready/rready low for 10 cycles keeps bvalid/rvalid high and blocks new acceptances.
- Reset mid-run: assert ARESET for 1 cycle in cycle 2 of a run. Required: BUSY = DONE = 0, DATA_OUT all 0, no bvalid/rvalid, and a subsequent normal run passes.
